// File: rtl/sha_pipelined_round_group_pkg.sv
// Shared SHA-256 types, constants and round primitives for the pipelined round groups.
package sha_pipelined_round_group_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } hash_state_t;

    // Word 0 of the window is the schedule word consumed by the current round.
    typedef logic [15:0][31:0] wwin_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_state_t SHA256_IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // One compression round on the working variables.
    function automatic hash_state_t sha_round(input hash_state_t s, input logic [31:0] k,
                                              input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        hash_state_t r;
        t1 = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
        t2 = big_sigma0(s.a) + maj(s.a, s.b, s.c);
        r.a = t1 + t2;
        r.b = s.a;
        r.c = s.b;
        r.d = s.c;
        r.e = s.d + t1;
        r.f = s.e;
        r.g = s.f;
        r.h = s.g;
        return r;
    endfunction

    // Slide the schedule window by one word and append the next expanded word.
    function automatic wwin_t window_step(input wwin_t w);
        wwin_t r;
        for (int i = 0; i < 15; i++) begin
            r[i] = w[i+1];
        end
        r[15] = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
        return r;
    endfunction

    // Per-word modular add used for the final digest.
    function automatic hash_state_t add_state(input hash_state_t x, input hash_state_t y);
        hash_state_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha_pipelined_round_group_stage.sv
// One registered SHA-256 round with its schedule-window step and sideband.
module sha_round_stage
    import sha_pipelined_round_group_pkg::*;
#(
    parameter int ROUND = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        valid_i,
    input  logic        newblock_i,
    input  hash_state_t state_i,
    input  hash_state_t chain_i,
    input  wwin_t       wwin_i,
    output logic        valid_o,
    output logic        newblock_o,
    output hash_state_t state_o,
    output hash_state_t chain_o,
    output wwin_t       wwin_o
);

    logic        valid_d, valid_q;
    logic        newblock_d, newblock_q;
    hash_state_t state_d, state_q;
    hash_state_t chain_d, chain_q;
    wwin_t       wwin_d, wwin_q;

    // Hold every register while stalled; otherwise run this round and advance the window.
    always_comb begin
        valid_d    = valid_q;
        newblock_d = newblock_q;
        state_d    = state_q;
        chain_d    = chain_q;
        wwin_d     = wwin_q;
        if (en) begin
            valid_d    = valid_i;
            newblock_d = newblock_i;
            state_d    = sha_round(state_i, K[ROUND], wwin_i[0]);
            chain_d    = chain_i;
            wwin_d     = window_step(wwin_i);
        end
    end

    // Stage registers, cleared immediately by reset so in-flight blocks are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            newblock_q <= 1'b0;
            state_q    <= '0;
            chain_q    <= '0;
            wwin_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            newblock_q <= newblock_d;
            state_q    <= state_d;
            chain_q    <= chain_d;
            wwin_q     <= wwin_d;
        end
    end

    assign valid_o    = valid_q;
    assign newblock_o = newblock_q;
    assign state_o    = state_q;
    assign chain_o    = chain_q;
    assign wwin_o     = wwin_q;

endmodule

// File: rtl/sha_pipelined_round_group.sv
// Chain of ROUNDS registered SHA-256 rounds starting at FIRST_ROUND, with optional digest add.
module sha_pipelined_round_group
    import sha_pipelined_round_group_pkg::*;
#(
    parameter int FIRST_ROUND = 0,
    parameter int ROUNDS      = 8,
    parameter int FEEDFORWARD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        valid_i,
    input  logic        newblock_i,
    input  hash_state_t state_i,
    input  hash_state_t chain_i,
    input  wwin_t       wwin_i,
    output logic        valid_o,
    output logic        newblock_o,
    output hash_state_t state_o,
    output hash_state_t chain_o,
    output wwin_t       wwin_o,
    output hash_state_t digest_o
);

    // The digest add only makes sense when this group finishes round 63.
    localparam bit FF_ACTIVE = (FEEDFORWARD == 1) && (FIRST_ROUND + ROUNDS == 64);

    logic        valid_s    [ROUNDS+1];
    logic        newblock_s [ROUNDS+1];
    hash_state_t state_s    [ROUNDS+1];
    hash_state_t chain_s    [ROUNDS+1];
    wwin_t       wwin_s     [ROUNDS+1];

    assign valid_s[0]    = valid_i;
    assign newblock_s[0] = newblock_i;
    assign state_s[0]    = state_i;
    assign chain_s[0]    = chain_i;
    assign wwin_s[0]     = wwin_i;

    genvar j;
    for (j = 0; j < ROUNDS; j++) begin : g_stage
        sha_round_stage #(
            .ROUND (FIRST_ROUND + j)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .valid_i    (valid_s[j]),
            .newblock_i (newblock_s[j]),
            .state_i    (state_s[j]),
            .chain_i    (chain_s[j]),
            .wwin_i     (wwin_s[j]),
            .valid_o    (valid_s[j+1]),
            .newblock_o (newblock_s[j+1]),
            .state_o    (state_s[j+1]),
            .chain_o    (chain_s[j+1]),
            .wwin_o     (wwin_s[j+1])
        );
    end

    assign valid_o    = valid_s[ROUNDS];
    assign newblock_o = newblock_s[ROUNDS];
    assign state_o    = state_s[ROUNDS];
    assign chain_o    = chain_s[ROUNDS];
    assign wwin_o     = wwin_s[ROUNDS];

    if (FF_ACTIVE) begin : g_ff
        hash_state_t digest_d, digest_q;

        // Recompute round 63 from the last stage inputs so the add lands on the same edge as state_o.
        always_comb begin
            digest_d = digest_q;
            if (en) begin
                digest_d = add_state(chain_s[ROUNDS-1],
                                     sha_round(state_s[ROUNDS-1], K[FIRST_ROUND+ROUNDS-1],
                                               wwin_s[ROUNDS-1][0]));
            end
        end

        // Digest register shares reset and stall behaviour with the stage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digest_q <= '0;
            end else begin
                digest_q <= digest_d;
            end
        end

        assign digest_o = digest_q;
    end else begin : g_no_ff
        assign digest_o = state_o;
    end

endmodule

// File: tb/tb_sha_pipelined_round_group.sv
// Bench for sha_pipelined_round_group: several split configurations against a schedule-array model.
module tb_sha_pipelined_round_group;
    import sha_pipelined_round_group_pkg::*;

    typedef struct packed {
        logic         valid;
        logic         nb;
        logic [255:0] state;
        logic [255:0] chain;
        logic [511:0] wwin;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         in_valid;
    logic         in_nb;
    logic [255:0] in_state;
    logic [255:0] in_chain;
    logic [511:0] in_wwin;

    int checks = 0;
    int errors = 0;
    rec_t hist [64];

    logic        d1_valid, d1_nb;
    hash_state_t d1_state, d1_chain, d1_dig;
    wwin_t       d1_wwin;
    logic        d8_valid, d8_nb;
    hash_state_t d8_state, d8_chain, d8_dig;
    wwin_t       d8_wwin;
    logic        da_valid, da_nb;
    hash_state_t da_state, da_chain, da_dig;
    wwin_t       da_wwin;
    logic        db_valid, db_nb;
    hash_state_t db_state, db_chain, db_dig;
    wwin_t       db_wwin;
    logic        r1_valid, r1_nb;
    hash_state_t r1_state, r1_chain, r1_dig;
    wwin_t       r1_wwin;
    logic        r2_valid, r2_nb;
    hash_state_t r2_state, r2_chain, r2_dig;
    wwin_t       r2_wwin;

    always #5 clk = ~clk;

    sha_pipelined_round_group #(.FIRST_ROUND(0), .ROUNDS(1), .FEEDFORWARD(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(in_valid), .newblock_i(in_nb),
        .state_i(in_state), .chain_i(in_chain), .wwin_i(in_wwin),
        .valid_o(d1_valid), .newblock_o(d1_nb), .state_o(d1_state), .chain_o(d1_chain),
        .wwin_o(d1_wwin), .digest_o(d1_dig));

    sha_pipelined_round_group #(.FIRST_ROUND(0), .ROUNDS(8), .FEEDFORWARD(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(in_valid), .newblock_i(in_nb),
        .state_i(in_state), .chain_i(in_chain), .wwin_i(in_wwin),
        .valid_o(d8_valid), .newblock_o(d8_nb), .state_o(d8_state), .chain_o(d8_chain),
        .wwin_o(d8_wwin), .digest_o(d8_dig));

    sha_pipelined_round_group #(.FIRST_ROUND(0), .ROUNDS(32), .FEEDFORWARD(0)) u_da (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(in_valid), .newblock_i(in_nb),
        .state_i(in_state), .chain_i(in_chain), .wwin_i(in_wwin),
        .valid_o(da_valid), .newblock_o(da_nb), .state_o(da_state), .chain_o(da_chain),
        .wwin_o(da_wwin), .digest_o(da_dig));

    sha_pipelined_round_group #(.FIRST_ROUND(32), .ROUNDS(32), .FEEDFORWARD(1)) u_db (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(da_valid), .newblock_i(da_nb),
        .state_i(da_state), .chain_i(da_chain), .wwin_i(da_wwin),
        .valid_o(db_valid), .newblock_o(db_nb), .state_o(db_state), .chain_o(db_chain),
        .wwin_o(db_wwin), .digest_o(db_dig));

    sha_pipelined_round_group #(.FIRST_ROUND(13), .ROUNDS(5), .FEEDFORWARD(0)) u_r1 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(in_valid), .newblock_i(in_nb),
        .state_i(in_state), .chain_i(in_chain), .wwin_i(in_wwin),
        .valid_o(r1_valid), .newblock_o(r1_nb), .state_o(r1_state), .chain_o(r1_chain),
        .wwin_o(r1_wwin), .digest_o(r1_dig));

    sha_pipelined_round_group #(.FIRST_ROUND(60), .ROUNDS(4), .FEEDFORWARD(1)) u_r2 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(in_valid), .newblock_i(in_nb),
        .state_i(in_state), .chain_i(in_chain), .wwin_i(in_wwin),
        .valid_o(r2_valid), .newblock_o(r2_nb), .state_o(r2_state), .chain_o(r2_chain),
        .wwin_o(r2_wwin), .digest_o(r2_dig));

    // Reference model helpers, written directly from the SHA-256 definitions.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    // Expand the full schedule array, run the rounds on an 8-word array, read the window back out.
    function automatic void ref_model(input logic [255:0] st_in, input logic [511:0] win_in,
                                      input int first, input int rounds,
                                      output logic [255:0] st_out, output logic [511:0] win_out);
        logic [31:0] w [80];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1, chv, mjv;
        for (int i = 0; i < 16; i++) w[i] = win_in[i*32 +: 32];
        for (int i = 16; i < rounds + 16; i++)
            w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = st_in[255-32*i -: 32];
        for (int j = 0; j < rounds; j++) begin
            s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
            s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
            chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
            mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = v[7] + s1 + chv + K[first+j] + w[j];
            t2  = s0 + mjv;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) st_out[255-32*i -: 32] = v[i];
        for (int i = 0; i < 16; i++) win_out[i*32 +: 32] = w[rounds+i];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare one group's outputs with the model applied to the block that entered lat edges ago.
    task automatic checkDut(input string name, input int lat, input int first, input bit ff,
                            input logic v, input logic nb, input logic [255:0] st,
                            input logic [255:0] ch, input logic [511:0] win,
                            input logic [255:0] dig);
        rec_t r;
        logic [255:0] est, edig;
        logic [511:0] ewin;
        r = hist[lat-1];
        checkOutput({name, ".valid"}, 512'(v), 512'(r.valid));
        if (r.valid) begin
            ref_model(r.state, r.wwin, first, lat, est, ewin);
            for (int i = 0; i < 8; i++)
                edig[i*32 +: 32] = ff ? est[i*32 +: 32] + r.chain[i*32 +: 32] : est[i*32 +: 32];
            checkOutput({name, ".newblock"}, 512'(nb), 512'(r.nb));
            checkOutput({name, ".state"}, 512'(st), 512'(est));
            checkOutput({name, ".chain"}, 512'(ch), 512'(r.chain));
            checkOutput({name, ".wwin"}, win, ewin);
            checkOutput({name, ".digest"}, 512'(dig), 512'(edig));
        end
    endtask

    task automatic checkZero(input string name, input logic v, input logic nb,
                             input logic [255:0] st, input logic [255:0] ch,
                             input logic [511:0] win, input logic [255:0] dig);
        checkOutput({name, ".rst_vs"}, 512'({v, nb, st}), 512'(0));
        checkOutput({name, ".rst_cd"}, {ch, dig}, 512'(0));
        checkOutput({name, ".rst_w"}, win, 512'(0));
    endtask

    task automatic checkAll();
        checkDut("d1", 1, 0, 1'b0, d1_valid, d1_nb, d1_state, d1_chain, d1_wwin, d1_dig);
        checkDut("d8", 8, 0, 1'b0, d8_valid, d8_nb, d8_state, d8_chain, d8_wwin, d8_dig);
        checkDut("da", 32, 0, 1'b0, da_valid, da_nb, da_state, da_chain, da_wwin, da_dig);
        checkDut("db", 64, 0, 1'b1, db_valid, db_nb, db_state, db_chain, db_wwin, db_dig);
        checkDut("r1", 5, 13, 1'b0, r1_valid, r1_nb, r1_state, r1_chain, r1_wwin, r1_dig);
        checkDut("r2", 4, 60, 1'b1, r2_valid, r2_nb, r2_state, r2_chain, r2_wwin, r2_dig);
    endtask

    task automatic checkZeroAll();
        checkZero("d1", d1_valid, d1_nb, d1_state, d1_chain, d1_wwin, d1_dig);
        checkZero("d8", d8_valid, d8_nb, d8_state, d8_chain, d8_wwin, d8_dig);
        checkZero("da", da_valid, da_nb, da_state, da_chain, da_wwin, da_dig);
        checkZero("db", db_valid, db_nb, db_state, db_chain, db_wwin, db_dig);
        checkZero("r1", r1_valid, r1_nb, r1_state, r1_chain, r1_wwin, r1_dig);
        checkZero("r2", r2_valid, r2_nb, r2_state, r2_chain, r2_wwin, r2_dig);
    endtask

    // Present one slot, let one rising edge pass, track what was captured, then check at the falling edge.
    task automatic applyStimulus(input logic v, input logic nb, input logic [255:0] st,
                                 input logic [255:0] ch, input logic [511:0] win);
        rec_t cur;
        in_valid = v;
        in_nb    = nb;
        in_state = st;
        in_chain = ch;
        in_wwin  = win;
        cur.valid = v;
        cur.nb    = nb;
        cur.state = st;
        cur.chain = ch;
        cur.wwin  = win;
        @(posedge clk);
        if (rst_n && en) begin
            for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 1'b0, rnd256(), rnd256(), rnd512());
    endtask

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIGEST_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIGEST_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    initial begin
        logic [511:0] abc_win;
        logic [511:0] empty_win;
        abc_win            = '0;
        abc_win[31:0]      = 32'h61626380;
        abc_win[511:480]   = 32'h00000018;
        empty_win          = '0;
        empty_win[31:0]    = 32'h80000000;
        for (int i = 0; i < 64; i++) hist[i] = '0;

        rst_n    = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_nb    = 1'b0;
        in_state = '0;
        in_chain = '0;
        in_wwin  = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkZeroAll();

        // Reset released but en low: nothing may be captured.
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, IV, IV, abc_win);

        // Back-to-back "abc" and empty message, then drain the longest pipeline.
        en = 1'b1;
        applyStimulus(1'b1, 1'b1, IV, IV, abc_win);
        checkOutput("d1.abc_a", 512'(d1_state.a), 512'(32'h5d6aebcd));
        checkOutput("d1.abc_e", 512'(d1_state.e), 512'(32'hfa2a4622));
        checkOutput("d1.abc_w0", 512'(d1_wwin[0]), 512'(32'h00000000));
        checkOutput("d1.abc_valid", 512'(d1_valid), 512'(1'b1));
        applyStimulus(1'b1, 1'b0, IV, IV, empty_win);
        for (int k = 3; k <= 70; k++) begin
            bubble();
            if (k == 8) checkOutput("d8.nb_first", 512'({d8_valid, d8_nb}), 512'(2'b11));
            if (k == 9) checkOutput("d8.nb_second", 512'({d8_valid, d8_nb}), 512'(2'b10));
            if (k == 64) checkOutput("db.digest_abc", 512'(db_dig), 512'(DIGEST_ABC));
            if (k == 65) checkOutput("db.digest_empty", 512'(db_dig), 512'(DIGEST_EMPTY));
        end

        // Stall for three edges with blocks in flight; junk offered during the stall is not taken.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), rnd256(), rnd256(), rnd512());
        for (int k = 0; k < 4; k++) bubble();
        en = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, rnd256(), rnd256(), rnd512());
        en = 1'b1;
        for (int k = 0; k < 70; k++) bubble();

        // Mid-stream reset discards in-flight work; a fresh block then completes normally.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, rnd256(), rnd256(), rnd512());
        for (int k = 0; k < 2; k++) bubble();
        rst_n = 1'b0;
        #1;
        checkZeroAll();
        for (int i = 0; i < 64; i++) hist[i] = '0;
        applyStimulus(1'b1, 1'b1, rnd256(), rnd256(), rnd512());
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, IV, IV, abc_win);
        for (int k = 2; k <= 70; k++) begin
            bubble();
            if (k == 8) checkOutput("d8.post_rst_valid", 512'(d8_valid), 512'(1'b1));
            if (k == 64) checkOutput("db.post_rst_digest", 512'(db_dig), 512'(DIGEST_ABC));
        end

        // Random traffic with random stalls across all split configurations.
        for (int k = 0; k < 300; k++) begin
            en = ($urandom_range(0, 7) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          rnd256(), rnd256(), rnd512());
        end
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_pipelined_round_group.md
# sha_pipelined_round_group

Parametrised successor to the single-round pre-stage. It executes ROUNDS consecutive SHA-256 compression rounds, starting at round index FIRST_ROUND, with one register stage per round. It carries the 16-word message-schedule window with the working state, so no external W feed is needed. It adds a global stall, asynchronous reset and an optional feed-forward (final digest add) when the group ends at round 63. Several groups are chained to build the full 64-round pipeline of the hashing core.

## Interface
- FIRST_ROUND, default 0: index of the first round executed (0..63).
- ROUNDS, default 8: rounds, and therefore pipeline stages, in this group (1..64). FIRST_ROUND+ROUNDS ≤ 64.
- FEEDFORWARD, default 0: when 1 and FIRST_ROUND+ROUNDS==64, digest_o = chain_o + state after round 63 (per-word mod 2^32). Otherwise digest_o = state_o.
- clk  in  1  clock, all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance. 0 freezes every register in the group.
- valid_i  in  1  input slot holds a live block.
- newblock_i  in  1  sideband flag, passed through aligned with the data.
- state_i  in  HashState  working variables a..h entering round FIRST_ROUND.
- chain_i  in  HashState  block-entry chaining value H, carried for the feed-forward.
- wwin_i  in  32×16  schedule window. Word 0 is W[FIRST_ROUND].
- valid_o, newblock_o  out  1  delayed sideband.
- state_o  out  HashState  state after round FIRST_ROUND+ROUNDS-1.
- chain_o  out  HashState  delayed chain_i.
- wwin_o  out  32×16  window advanced ROUNDS times.
- digest_o  out  HashState  see FEEDFORWARD.

## Operation
- Stage j (0..ROUNDS-1) executes round t = FIRST_ROUND+j using K[t] and W = window word 0.
- Round function:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W
  - T2 = Σ0(a) + Maj(a,b,c)
  - New state = {T1+T2, a, b, c, d+T1, e, f, g}
  - All sums are mod 2^32.
- Window step each stage:
  - w'[i] = w[i+1] for i = 0..14.
  - w'[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32.
  - The same step applies for all t. For t<16 the incoming window already holds the message words.
- valid, newblock and chain travel with their slot through every stage.
- Data registers load regardless of valid. Bubbles carry don't-care data, and valid_o=0 marks them.
- Feed-forward is a registered add in the final stage, aligned with state_o. It adds no extra latency.

## Timing
- Latency is exactly ROUNDS cycles with en=1 each cycle. One block per cycle of throughput.
- en=0 on an edge: no register changes and outputs hold. The slot seen at the inputs on that edge is not captured. The upstream holds it and re-presents it.
- Reset asserted, at any time including mid-stream: every stage register, valid_o, newblock_o, state_o, chain_o, wwin_o and digest_o clear to 0 immediately. In-flight blocks are discarded.
- First capture after reset is on the first rising edge with rst_n=1 and en=1.
- newblock is sideband only. It does not alter the datapath.
- ROUNDS=1 degenerates to a single registered round plus window step.

## Structure
- Shared package:
  - HashState struct (a..h, 32 bits each).
  - K[0:63] constant array.
  - SHA-256 IV constant.
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
- One sub-module, sha_round_stage: a single registered round plus window step with en/rst_n and sideband, parametrised by round index. The group is a generate chain of ROUNDS instances plus the optional feed-forward register.

## Test plan
- FIRST_ROUND=0, ROUNDS=1, state_i=IV, wwin_i = padded "abc" (w0=61626380, w15=00000018, rest 0), valid_i=1 → after 1 cycle: state_o.a=5d6aebcd, state_o.e=fa2a4622, wwin_o word0=00000000, valid_o=1.
- Chain FIRST_ROUND=0/ROUNDS=32 and FIRST_ROUND=32/ROUNDS=32 with FEEDFORWARD=1, chain_i=IV, "abc" → after 64 cycles: digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- ROUNDS=8: back-to-back "abc" and empty message (w0=80000000, rest 0), newblock_i=1 on the first only → outputs on consecutive cycles 8 and 9 after issue, newblock_o 1 then 0. Each matches the golden model.
- Hold en=0 for 3 cycles while 4 blocks are in flight → outputs frozen during the hold. Total latency becomes ROUNDS+3. Results are unchanged.
- Assert rst_n=0 mid-stream for one cycle → all outputs are 0 immediately. No valid_o appears for pre-reset blocks. The next block issued completes correctly after ROUNDS cycles.
- Random sweep of FIRST_ROUND/ROUNDS splits versus the reference model → state, window and sideband are bit-exact.
